dmem_lsu_ctrl: RTL and testbench

- Load/store initiator that drives the dual-port byte-lane data memory on behalf of the single-cycle/multi-cycle CPU core.
- Takes one RISC-V load/store request at a time and generates the memory port signals: port A (ena/wea/addra/dina) for writes, port B (enb/addrb/doutb) for reads.
- Performs byte/halfword extraction with sign/zero extension, sub-word read-modify-write merge, and misalignment/illegal-width detection.
- Sits between the core's memory stage and the data memory instance.

---
 rtl/dmem_lsu_ctrl.sv | 129 ++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: RV32I load/store initiator for a dual-port byte-lane data memory
module dmem_lsu_ctrl #(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_ena,
  output logic [3:0]        mem_wea,
  output logic [MEM_AW-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  output logic              mem_enb,
  output logic [MEM_AW-1:0] mem_addrb,
  input  logic [31:0]       mem_doutb
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, LRSP, SRSP, ERR} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [MEM_AW-1:0] waddr_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              accept, bad_f3, misal, illegal, unused_addr;
  logic [4:0]        sh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_data, merge_data;

  assign accept      = req_valid & (state_q == IDLE);
  assign unused_addr = ^req_addr[31:MEM_AW+2];
  assign bad_f3      = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) | (req_we & req_funct3[2]);
  assign misal       = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
  assign illegal     = bad_f3 | misal;

  // state register; reset discards any in-flight request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // request capture on accept; held stable for the whole transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      waddr_q <= '0;
      off_q   <= 2'b00;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      waddr_q <= req_addr[MEM_AW+1:2];
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
  end

  // lane extraction for loads and read-modify-write merge for sub-word stores
  always_comb begin
    sh         = {off_q, 3'b000};
    byte_v     = 8'(mem_doutb >> sh);
    half_v     = off_q[1] ? mem_doutb[31:16] : mem_doutb[15:0];
    load_data  = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
                 (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half_v[15]}}, half_v} : mem_doutb;
    merge_data = (f3_q[1:0] == 2'b00) ? ((mem_doutb & ~(32'h0000_00FF << sh)) | ({24'b0, wdata_q[7:0]} << sh)) :
                 (f3_q[1:0] == 2'b01) ? (off_q[1] ? {wdata_q[15:0], mem_doutb[15:0]} : {mem_doutb[31:16], wdata_q[15:0]}) :
                 wdata_q;
  end

  // next-state and Moore outputs; every output idles at zero
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_ena    = 1'b0;
    mem_wea    = 4'b0000;
    mem_addra  = '0;
    mem_dina   = '0;
    mem_enb    = 1'b0;
    mem_addrb  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal ? ERR : (req_we && req_funct3 == 3'b010) ? WRITE : READ;
      end
      READ: begin
        mem_enb   = 1'b1;
        mem_addrb = waddr_q;
        state_d   = we_q ? WRITE : LRSP;
      end
      WRITE: begin
        mem_ena   = 1'b1;
        mem_wea   = 4'b1111;
        mem_addra = waddr_q;
        mem_dina  = merge_data;
        state_d   = SRSP;
      end
      LRSP: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
        state_d    = IDLE;
      end
      SRSP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: scoreboard bench for dmem_lsu_ctrl with a behavioural dual-port memory
module tb_dmem_lsu_ctrl;

  localparam int AW = 15;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    logic [31:0] dina;
    bit          cd;
    bit          nomem;
    bit          noenb;
  } exp_t;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_ena, mem_enb;
  logic [31:0]   resp_rdata, mem_dina;
  logic [31:0]   mem_doutb = '0;
  logic [3:0]    mem_wea;
  logic [AW-1:0] mem_addra, mem_addrb;

  logic [31:0] mem [0:(1<<AW)-1];
  exp_t        sb_q[$];
  int          acc_q[$];
  exp_t        e_cur;
  int          a_cur;
  int          cyc = 0, n_acc = 0, n_tests = 0, n_fail = 0;
  bit          saw_ena = 0, saw_enb = 0, prev_rv = 0;

  dmem_lsu_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // registered read port
  always @(posedge clk) if (mem_enb) mem_doutb <= mem[mem_addrb];

  // write port commits on the falling edge
  always @(negedge clk) if (mem_ena) for (int i = 0; i < 4; i++) if (mem_wea[i]) mem[mem_addra][8*i +: 8] <= mem_dina[8*i +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // response monitor: pops the scoreboard on each resp_valid
  always @(negedge clk) if (rstn) begin
    if (req_valid && req_ready) begin
      acc_q.push_back(cyc + 1);
      n_acc++;
      saw_ena = 0;
      saw_enb = 0;
    end
    if (mem_ena) begin
      saw_ena = 1;
      chk("wea", {28'b0, mem_wea}, 32'hF);
      if (sb_q.size() > 0 && sb_q[0].cd) chk("dina", mem_dina, sb_q[0].dina);
    end
    if (mem_enb) saw_enb = 1;
    if (resp_valid) begin
      chk("rv_twice", {31'b0, prev_rv}, 32'd0);
      if (sb_q.size() == 0 || acc_q.size() == 0) chk("unexp_resp", {31'b0, resp_valid}, 32'd0);
      else begin
        e_cur = sb_q.pop_front();
        a_cur = acc_q.pop_front();
        chk("err", {31'b0, resp_err}, {31'b0, e_cur.err});
        chk("rdata", resp_rdata, e_cur.rd);
        chk("lat", 32'(cyc - a_cur + 1), 32'(e_cur.lat));
        if (e_cur.nomem) chk("no_mem", {31'b0, saw_ena | saw_enb}, 32'd0);
        if (e_cur.noenb) chk("no_enb", {31'b0, saw_enb}, 32'd0);
      end
    end
    prev_rv = resp_valid;
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input int lat,
                      input logic [31:0] dina, input bit cd, input bit nomem, input bit noenb, input bit keep);
    exp_t e;
    bit ok;
    e = '{err, rd, lat, dina, cd, nomem, noenb};
    sb_q.push_back(e);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    chk("accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 1'b0;
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
        @(posedge clk); #1;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    send(1'b0, f3, a, 32'h0, 1'b0, rd, 2, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    send(we, f3, a, 32'h1234_5678, 1'b1, 32'h0, 1, 32'h0, 0, 1, 0, 0);
  endtask

  initial begin
    logic [31:0] old_w;
    int acc0;
    bit ok;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[15'h40] = 32'h8812_34F0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rv", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ena", {31'b0, mem_ena}, 32'd0);
    chk("rst_wea", {28'b0, mem_wea}, 32'd0);
    chk("rst_enb", {31'b0, mem_enb}, 32'd0);
    chk("rst_addra", {17'b0, mem_addra}, 32'd0);
    chk("rst_addrb", {17'b0, mem_addrb}, 32'd0);
    chk("rst_dina", mem_dina, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    ld(3'b000, 32'h103, 32'hFFFF_FF88);
    ld(3'b100, 32'h103, 32'h0000_0088);
    ld(3'b001, 32'h100, 32'h0000_34F0);
    ld(3'b101, 32'h102, 32'h0000_8812);
    ld(3'b001, 32'h102, 32'hFFFF_8812);
    send(1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 1'b0, 32'h0, 3, 32'hBEEF_34F0, 1, 0, 0, 0);
    ld(3'b010, 32'h100, 32'hBEEF_34F0);
    send(1'b1, 3'b010, 32'h200, 32'hCAFE_BABE, 1'b0, 32'h0, 2, 32'hCAFE_BABE, 1, 0, 1, 0);
    ld(3'b010, 32'h200, 32'hCAFE_BABE);
    ld(3'b010, 32'h0002_0200, 32'hCAFE_BABE);
    bad(1'b0, 3'b010, 32'h102);
    bad(1'b1, 3'b001, 32'h101);
    bad(1'b0, 3'b011, 32'h100);
    bad(1'b1, 3'b100, 32'h100);
    bad(1'b0, 3'b111, 32'h100);
    chk("err_mem", mem[15'h40], 32'hBEEF_34F0);
    send(1'b1, 3'b000, 32'h101, 32'h0000_0077, 1'b0, 32'h0, 3, 32'hBEEF_77F0, 1, 0, 0, 0);
    ld(3'b010, 32'h100, 32'hBEEF_77F0);
    acc0 = n_acc;
    send(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'hCAFE_BABE, 2, 32'h0, 0, 0, 0, 1);
    send(1'b0, 3'b000, 32'h100, 32'h0, 1'b0, 32'hFFFF_FFF0, 2, 32'h0, 0, 0, 0, 1);
    send(1'b1, 3'b010, 32'h300, 32'h1234_5678, 1'b0, 32'h0, 2, 32'h1234_5678, 1, 0, 1, 0);
    chk("hold_accepts", 32'(n_acc - acc0), 32'd3);
    chk("hold_mem", mem[15'hC0], 32'h1234_5678);
    old_w = mem[15'h40];
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = mem_ena;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("rst_reach_write", {31'b0, ok}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_ena", {31'b0, mem_ena}, 32'd0);
    chk("arst_enb", {31'b0, mem_enb}, 32'd0);
    chk("arst_wea", {28'b0, mem_wea}, 32'd0);
    chk("arst_rv", {31'b0, resp_valid}, 32'd0);
    chk("arst_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("arst_word", {31'b0, (mem[15'h40] == old_w) || (mem[15'h40] == 32'hBEEF_7755)}, 32'd1);
    chk("arst_word_old", mem[15'h40], old_w);
    rstn = 1'b1;
    acc_q.delete();
    sb_q.delete();
    @(posedge clk); #1;
    ld(3'b010, 32'h100, old_w);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
